// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register view shared by the hazard controller and the datapath:
// decoded instructions in, stall/bubble and multiply/divide controls out.
interface pipe_hazard_ctrl_if;
   logic [31:0] instr_D;
   logic [31:0] instr_E;
   logic [31:0] instr_M;
   logic        pc_en;
   logic        d_en;
   logic        e_clear;
   logic        md_start;
   logic        md_busy;

   modport master (
      output instr_D, instr_E, instr_M,
      input  pc_en, d_en, e_clear, md_start, md_busy
   );

   modport slave (
      input  instr_D, instr_E, instr_M,
      output pc_en, d_en, e_clear, md_start, md_busy
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline: data-hazard
// stalls from Tuse/Tnew comparison plus the multiply/divide busy counter.
module pipe_hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave hz
);

   typedef struct packed {
      logic cal_r;
      logic cal_i;
      logic load;
      logic store;
      logic br_rs_rt;
      logic br_rs;
      logic jr;
      logic jalr;
      logic jal;
      logic md;
      logic mul;
      logic div;
   } cls_t;

   typedef struct packed {
      logic       rs_en;
      logic [1:0] rs_tuse;
      logic       rt_en;
      logic [1:0] rt_tuse;
      logic       md;
   } src_t;

   // The all-zero word is the bubble nop and must not decode as sll.
   function automatic cls_t classify(input logic [31:0] ins);
      cls_t c;
      c = '0;
      if (ins != 32'h0) begin
         case (ins[31:26])
            6'h00: begin
               case (ins[5:0])
                  6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                  6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                  6'h2A, 6'h2B: c.cal_r = 1'b1;
                  6'h10, 6'h12: begin c.cal_r = 1'b1; c.md = 1'b1; end
                  6'h11, 6'h13: c.md = 1'b1;
                  6'h18, 6'h19: begin c.md = 1'b1; c.mul = 1'b1; end
                  6'h1A, 6'h1B: begin c.md = 1'b1; c.div = 1'b1; end
                  6'h08: c.jr = 1'b1;
                  6'h09: c.jalr = 1'b1;
                  default: ;
               endcase
            end
            6'h01: c.br_rs = (ins[20:17] == 4'd0);
            6'h04, 6'h05: c.br_rs_rt = 1'b1;
            6'h06, 6'h07: c.br_rs = 1'b1;
            6'h03: c.jal = 1'b1;
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c.cal_i = 1'b1;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c.load = 1'b1;
            6'h28, 6'h29, 6'h2B: c.store = 1'b1;
            default: ;
         endcase
      end
      return c;
   endfunction

   function automatic logic [4:0] dest_of(input logic [31:0] ins);
      cls_t c;
      c = classify(ins);
      if (c.cal_r || c.jalr)      return ins[15:11];
      else if (c.cal_i || c.load) return ins[20:16];
      else if (c.jal)             return 5'd31;
      else                        return 5'd0;
   endfunction

   function automatic src_t src_info(input logic [31:0] ins);
      cls_t c;
      src_t s;
      c = classify(ins);
      s = '0;
      if (c.br_rs_rt || c.br_rs || c.jr || c.jalr) begin
         s.rs_en = 1'b1;
         s.rs_tuse = 2'd0;
      end else if (c.cal_r || c.cal_i || c.md || c.load || c.store) begin
         s.rs_en = 1'b1;
         s.rs_tuse = 2'd1;
      end
      if (c.br_rs_rt) begin
         s.rt_en = 1'b1;
         s.rt_tuse = 2'd0;
      end else if (c.cal_r || c.md) begin
         s.rt_en = 1'b1;
         s.rt_tuse = 2'd1;
      end else if (c.store) begin
         s.rt_en = 1'b1;
         s.rt_tuse = 2'd2;
      end
      s.md = c.md;
      return s;
   endfunction

   function automatic logic [1:0] tnew_e_of(input logic [31:0] ins);
      cls_t c;
      c = classify(ins);
      if (c.load)                 return 2'd2;
      else if (c.cal_r || c.cal_i) return 2'd1;
      else                        return 2'd0;
   endfunction

   function automatic logic [1:0] tnew_m_of(input logic [31:0] ins);
      cls_t c;
      c = classify(ins);
      return c.load ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [1:0] md_kind(input logic [31:0] ins);
      cls_t c;
      c = classify(ins);
      return {c.div, c.mul};
   endfunction

   function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse,
                                input logic [4:0] dst, input logic [1:0] tnew);
      return (src != 5'd0) && (src == dst) && (tuse < tnew);
   endfunction

   src_t       src_d;
   logic [4:0] rs_d, rt_d, dest_e, dest_m;
   logic [1:0] tnew_e, tnew_m, kind_e;
   logic       md_start, md_busy, stall_data, stall_md, stall;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      src_d  = src_info(hz.instr_D);
      rs_d   = hz.instr_D[25:21];
      rt_d   = hz.instr_D[20:16];
      dest_e = dest_of(hz.instr_E);
      dest_m = dest_of(hz.instr_M);
      tnew_e = tnew_e_of(hz.instr_E);
      tnew_m = tnew_m_of(hz.instr_M);
      kind_e = md_kind(hz.instr_E);
   end

   // A single stall covers both data and MD hazards; E always advances, so a
   // launching mult/div leaves E after one cycle and pulses md_start once.
   always_comb begin
      md_start   = |kind_e;
      md_busy    = (cnt_q != 4'd0);
      stall_data = (src_d.rs_en && (hit(rs_d, src_d.rs_tuse, dest_e, tnew_e) ||
                                    hit(rs_d, src_d.rs_tuse, dest_m, tnew_m))) ||
                   (src_d.rt_en && (hit(rt_d, src_d.rt_tuse, dest_e, tnew_e) ||
                                    hit(rt_d, src_d.rt_tuse, dest_m, tnew_m)));
      stall_md   = src_d.md && (md_busy || md_start);
      stall      = stall_data || stall_md;
      hz.pc_en    = ~stall;
      hz.d_en     = ~stall;
      hz.e_clear  = stall;
      hz.md_start = md_start;
      hz.md_busy  = md_busy;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (md_start) begin
         cnt_d = kind_e[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus a
// randomized instruction stream compared every cycle against a rule-level model.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;
   int   cycleNum = 0;
   int   mdFreeAt = 0;
   bit   checkEn = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hif ();

   pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   // Rule-level view of one instruction: destination, producer latencies per
   // stage, consumer Tuse per source (-1 = not a source), MD class and busy length.
   function automatic void refDecode(input logic [31:0] ins, output int dest,
                                     output int tnE, output int tnM, output int useRs,
                                     output int useRt, output bit mdClass, output int mdLen);
      int op, fn, rt, rd;
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      dest = 0; tnE = 0; tnM = 0; useRs = -1; useRt = -1; mdClass = 0; mdLen = 0;
      if (ins == 32'h0) return;
      if (op == 0) begin
         if (fn inside {'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B,
                        'h00, 'h02, 'h03, 'h04, 'h06, 'h07}) begin
            dest = rd; tnE = 1; useRs = 1; useRt = 1;
         end else if (fn inside {'h10, 'h12}) begin
            dest = rd; tnE = 1; useRs = 1; useRt = 1; mdClass = 1;
         end else if (fn inside {'h11, 'h13}) begin
            useRs = 1; useRt = 1; mdClass = 1;
         end else if (fn inside {'h18, 'h19}) begin
            useRs = 1; useRt = 1; mdClass = 1; mdLen = 5;
         end else if (fn inside {'h1A, 'h1B}) begin
            useRs = 1; useRt = 1; mdClass = 1; mdLen = 10;
         end else if (fn == 'h08) begin
            useRs = 0;
         end else if (fn == 'h09) begin
            useRs = 0; dest = rd;
         end
      end else if (op inside {'h04, 'h05}) begin
         useRs = 0; useRt = 0;
      end else if (op inside {'h06, 'h07} || (op == 1 && rt <= 1)) begin
         useRs = 0;
      end else if (op == 'h03) begin
         dest = 31;
      end else if (op inside {'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F}) begin
         dest = rt; tnE = 1; useRs = 1;
      end else if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) begin
         dest = rt; tnE = 2; tnM = 1; useRs = 1;
      end else if (op inside {'h28, 'h29, 'h2B}) begin
         useRs = 1; useRt = 2;
      end
   endfunction

   function automatic bit modelMdStart();
      int d, a, b, u, v, len;
      bit m;
      refDecode(hif.instr_E, d, a, b, u, v, m, len);
      return len != 0;
   endfunction

   function automatic bit modelMdBusy();
      return cycleNum < mdFreeAt;
   endfunction

   function automatic bit modelStall();
      int dE, tE, tmE, uE1, uE2, lenE, dM, tM1, tM, uM1, uM2, lenM, dD, a, b, uRs, uRt, lenD;
      bit mE, mM, mD, s;
      int srcReg[2];
      int srcUse[2];
      refDecode(hif.instr_E, dE, tE, tmE, uE1, uE2, mE, lenE);
      refDecode(hif.instr_M, dM, tM1, tM, uM1, uM2, mM, lenM);
      refDecode(hif.instr_D, dD, a, b, uRs, uRt, mD, lenD);
      srcReg[0] = int'(hif.instr_D[25:21]); srcUse[0] = uRs;
      srcReg[1] = int'(hif.instr_D[20:16]); srcUse[1] = uRt;
      s = 0;
      for (int k = 0; k < 2; k++) begin
         if (srcUse[k] >= 0 && srcReg[k] != 0) begin
            if (srcReg[k] == dE && srcUse[k] < tE) s = 1;
            if (srcReg[k] == dM && srcUse[k] < tM) s = 1;
         end
      end
      if (mD && (modelMdBusy() || modelMdStart())) s = 1;
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual,
                  expected, cycleNum);
      end
   endtask

   // Model time base: the MD unit is free from the first cycle after launch+len.
   always @(posedge clk) begin
      if (reset) begin
         mdFreeAt = cycleNum + 1;
      end else if (modelMdStart()) begin
         int d, a, b, u, v, len;
         bit m;
         refDecode(hif.instr_E, d, a, b, u, v, m, len);
         mdFreeAt = cycleNum + 1 + len;
      end
      cycleNum++;
   end

   always @(negedge clk) begin
      if (checkEn) begin
         bit s;
         s = modelStall();
         checkOutput("pc_en", {31'b0, hif.pc_en}, {31'b0, !s});
         checkOutput("d_en", {31'b0, hif.d_en}, {31'b0, !s});
         checkOutput("e_clear", {31'b0, hif.e_clear}, {31'b0, s});
         checkOutput("md_start", {31'b0, hif.md_start}, {31'b0, modelMdStart()});
         checkOutput("md_busy", {31'b0, hif.md_busy}, {31'b0, modelMdBusy()});
      end
   end

   task automatic stepPipe(input logic [31:0] nextD);
      bit s;
      s = modelStall();
      @(posedge clk);
      #1;
      hif.instr_M = hif.instr_E;
      if (s) begin
         hif.instr_E = 32'h0;
      end else begin
         hif.instr_E = hif.instr_D;
         hif.instr_D = nextD;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 14; i++) stepPipe(32'h0);
   endtask

   task automatic applyStimulus(input logic [31:0] e, input logic [31:0] d, input int ncyc,
                                output int stalls, output int starts);
      hif.instr_M = 32'h0;
      hif.instr_E = e;
      hif.instr_D = d;
      stalls = 0;
      starts = 0;
      for (int i = 0; i < ncyc; i++) begin
         #2;
         if (hif.pc_en !== 1'b1) stalls++;
         if (hif.md_start === 1'b1) starts++;
         stepPipe(32'h0);
      end
      drain();
   endtask

   function automatic logic [31:0] randInstr();
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 14))
         0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         1:  return {6'h09, rs, rt, 16'h0004};
         2:  return {6'h23, rs, rt, 16'h0000};
         3:  return {6'h2B, rs, rt, 16'h0008};
         4:  return {6'h04, rs, rt, 16'h0002};
         5:  return {6'h01, rs, 5'd1, 16'h0002};
         6:  return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
         7:  return {6'h03, 26'h0000010};
         8:  return {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
         9:  return {6'h00, rs, rt, 5'd0, 5'd0, 6'h18};
         10: return {6'h00, rs, rt, 5'd0, 5'd0, 6'h1A};
         11: return {6'h00, 5'd0, 5'd0, rd, 5'd0, 6'h12};
         12: return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h11};
         13: return {6'h0F, 5'd0, rt, 16'h1234};
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      int stalls, starts;
      reset = 1'b1;
      hif.instr_D = 32'h0;
      hif.instr_E = 32'h0;
      hif.instr_M = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkEn = 1'b1;
      #2;
      checkOutput("reset_pc_en", {31'b0, hif.pc_en}, 32'd1);
      checkOutput("reset_d_en", {31'b0, hif.d_en}, 32'd1);
      checkOutput("reset_e_clear", {31'b0, hif.e_clear}, 32'd0);
      checkOutput("reset_md_start", {31'b0, hif.md_start}, 32'd0);
      checkOutput("reset_md_busy", {31'b0, hif.md_busy}, 32'd0);
      stepPipe(32'h0);

      applyStimulus(32'h8C010000, 32'h00211021, 6, stalls, starts);
      checkOutput("load_use_stall_len", stalls, 32'd1);
      applyStimulus(32'h00430821, 32'h10200000, 6, stalls, starts);
      checkOutput("alu_branch_stall_len", stalls, 32'd1);
      applyStimulus(32'h8C010000, 32'h10200000, 6, stalls, starts);
      checkOutput("load_branch_stall_len", stalls, 32'd2);
      applyStimulus(32'h00220018, 32'h00001812, 16, stalls, starts);
      checkOutput("mult_stall_len", stalls, 32'd6);
      checkOutput("mult_start_pulses", starts, 32'd1);
      applyStimulus(32'h0022001A, 32'h00001812, 20, stalls, starts);
      checkOutput("div_stall_len", stalls, 32'd11);
      checkOutput("div_start_pulses", starts, 32'd1);
      applyStimulus(32'h8C000000, 32'h00001021, 6, stalls, starts);
      checkOutput("reg0_no_stall", stalls, 32'd0);

      // Reset three cycles into a divide must free the waiting mflo at once.
      hif.instr_M = 32'h0;
      hif.instr_E = 32'h0022001A;
      hif.instr_D = 32'h00001812;
      for (int i = 0; i < 3; i++) stepPipe(32'h0);
      reset = 1'b1;
      stepPipe(32'h0);
      reset = 1'b0;
      #2;
      checkOutput("reset_mid_div_busy", {31'b0, hif.md_busy}, 32'd0);
      checkOutput("reset_mid_div_pc_en", {31'b0, hif.pc_en}, 32'd1);
      drain();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         stepPipe(randInstr());
         reset = 1'b0;
      end
      drain();

      @(posedge clk);
      #1;
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. It decodes the instructions held in the D, E and M pipeline registers. It drives the PC/D-register enable and the E-register clear, which stall the front end and inject bubbles. It also owns the multiply/divide busy counter: it launches MD operations and holds back any later MD-class instruction until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after launch for mult/multu.
- DIV_CYCLES, 10, busy cycles after launch for div/divu.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- instr_D  input  32  instruction in the D register.
- instr_E  input  32  instruction in the E register.
- instr_M  input  32  instruction in the M register.
- pc_en  output  1  PC write enable; 0 during a stall.
- d_en  output  1  D-register enable; equals pc_en.
- e_clear  output  1  E-register clear (bubble insert); equals ~pc_en.
- md_start  output  1  one-cycle launch pulse to the MD unit.
- md_busy  output  1  MD counter non-zero.

## Operation
Decode classes (opcode/funct):
- cal_r: SPECIAL addu/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/sllv/srlv/srav, plus mfhi/mflo.
- cal_i: addiu/andi/ori/xori/lui/slti/sltiu.
- load: lw/lh/lhu/lb/lbu. store: sw/sh/sb.
- branch: beq/bne/blez/bgtz/bltz/bgez. jr/jalr. jal.
- md: mult/multu/div/divu/mthi/mtlo/mfhi/mflo.

Destination register:
- cal_r and jalr write rd.
- cal_i and load write rt.
- jal writes 31.
- All other classes write none (0).

Tuse, for a source register of instr_D:
- branch rs/rt and jr/jalr rs: 0.
- cal_r/cal_i/md/load/store rs, and cal_r/md rt: 1.
- store rt: 2.

Tnew, for an instruction in E:
- load: 2.
- cal_r/cal_i: 1.
- jal/jalr: 0.

Tnew, for an instruction in M:
- load: 1.
- all other classes: 0.

Data-stall rule:
- stall_data = 1 if any source of instr_D has a non-zero register number equal to the destination of E (or M) and Tuse < Tnew of that stage.
- Register 0 never stalls.

MD counter:
- 4-bit down-counter cnt; md_busy = (cnt != 0).
- md_start = 1 when instr_E is mult/multu/div/divu.
- On the edge where md_start is 1, cnt loads MULT_CYCLES or DIV_CYCLES.
- Otherwise cnt decrements if non-zero, saturating at 0.
- mthi/mtlo do not start the counter.
- stall_md = instr_D is md-class and (md_busy or md_start).

Stall outputs:
- stall = stall_data | stall_md.
- pc_en = d_en = ~stall; e_clear = stall.
- The E stage always advances, so each E-stage mult/div produces exactly one md_start pulse.
- A cleared E register holds instr 0 (nop), which decodes to no class.

## Timing
- pc_en, d_en, e_clear, md_start are combinational from the instr inputs and cnt; md_busy is combinational from cnt.
- Reset clears cnt to 0 on the next rising edge. Post-reset outputs with nop inputs: pc_en=1, d_en=1, e_clear=0, md_start=0, md_busy=0.
- Reset mid-busy: cnt goes to 0 at that edge and any pending stall_md is released.
- Stall length for an md-class instr_D behind a mult (N=5) entering E: 1 cycle (start) + N busy cycles = 6 stalled cycles. D proceeds on the cycle where cnt reaches 0. For div the stall is 11 cycles.
- Load-use stall is 1 cycle: after the bubble the load sits in M with Tnew 1, which is not > Tuse 1.
- Simultaneous stall_data and stall_md: the single stall covers both; no double counting.

## Test plan
- Reset with all instr = 0 -> pc_en=1, d_en=1, e_clear=0, md_busy=0, md_start=0.
- instr_E=0x8C010000 (lw $1,0($0)), instr_D=0x00211021 (addu $2,$1,$1) -> stall exactly 1 cycle. The next cycle, with lw in M, gives pc_en=1.
- instr_E=0x00430821 (addu $1,$2,$3), instr_D=0x10200000 (beq $1,$0) -> e_clear=1 for 1 cycle. With lw $1 in E, the stall lasts 2 cycles.
- instr_E=0x00220018 (mult), instr_D=0x00001812 (mflo) -> md_start=1 for 1 cycle and pc_en=0 for 6 cycles. With 0x0022001A (div), pc_en=0 for 11 cycles.
- Assert reset 3 cycles into a div busy period -> md_busy=0 and pc_en=1 after that edge.
- instr_E=0x8C000000 (lw $0), instr_D=0x00001021 (addu $2,$0,$0) -> no stall, pc_en=1.
